instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
// - Boot-time sequencer for instruction-memory port B: accepts a byte stream, packs little-endian 32-bit
//   instruction words, writes them at consecutive word addresses from 0, and holds the core in reset until done.
// - Sits between the host/debug link and the port-B pins of the instruction memory (clkb tied to clk).
// PARAMETERS
// - INSTR_MEM_LEN  15  byte-address width of port B; capacity CAP = 2^(INSTR_MEM_LEN-2) words
// - INSTR_WIDTH    32  instruction/word width; must be 32 (4 bytes per word)
// PORTS
// - clk            in   1              single clock
// - rst            in   1              asynchronous, active-high reset
// - start          in   1              1-cycle pulse, begin a load; honoured in IDLE/DONE/ERR only
// - len_words      in   32             words to load, sampled on accepted start
// - abort          in   1              cancel load, return to IDLE
// - s_valid        in   1              byte stream valid
// - s_data         in   8              byte stream data
// - s_ready        out  1              byte accepted when s_valid & s_ready
// - mem_en         out  1              port-B enable
// - mem_we         out  4              port-B byte write enables
// - mem_addr       out  INSTR_MEM_LEN  port-B byte address (word_idx<<2; memory drops low 2 bits)
// - mem_din        out  32             port-B write data
// - core_rst       out  1              pipeline reset request, 1 while not DONE
// - busy           out  1              1 in RECV/WRITE(/CSUM)
// - done           out  1              1 in DONE
// - err            out  1              1 in ERR
// - words_written  out  INSTR_MEM_LEN-1  count of words committed this load
// BEHAVIOUR
// - Reset: state=IDLE, s_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, core_rst=1, busy=0, done=0,
//   err=0, words_written=0, byte_cnt=0.
// - IDLE/DONE/ERR + start: len_words==0 -> DONE next cycle; len_words>CAP -> ERR, no writes;
//   else words_written=0, byte_cnt=0, core_rst=1, -> RECV.
// - RECV: s_ready=1; each handshake shifts byte into word[8*byte_cnt +: 8] (first byte = bits 7:0).
//   4th byte -> WRITE next cycle.
// - WRITE (exactly 1 cycle, s_ready=0): mem_en=1, mem_we=4'hF, mem_addr=words_written<<2, mem_din=word.
//   Then words_written+1. If words_written+1==len_words -> DONE (or CSUM), else RECV.
// - Write latency: last byte of a word accepted at cycle N -> write strobe at cycle N+1.
// - Max throughput: 4 bytes per 5 cycles.
// - mem_en/mem_we are 0 in every state except WRITE; no partial-word writes ever issued.
// - DONE: core_rst=0, done=1; held until next start or abort.
//   start in DONE re-asserts core_rst the following cycle.
// - ERR: core_rst=1, err=1; held until start or abort.
// - abort (any state, priority over start and stream): -> IDLE next cycle, core_rst=1, partial word discarded.
//   Words already written stay in memory.
// - start while busy: ignored. s_valid while not in RECV: not accepted (s_ready=0).
// - Async rst mid-load: immediate return to reset values; partially loaded memory untouched.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined: after the last WRITE, go to CSUM (s_ready=1) and accept 4 more bytes
//   (little-endian). Compare with running sum of all written words mod 2^32: match -> DONE, mismatch -> ERR.
//   Running sum cleared on start.
// - LOADER_CHECKSUM_EN undefined: no CSUM state, no adder; last WRITE goes straight to DONE.
// TESTING
// - Reset -> core_rst=1, s_ready=0, mem_en=0, done=0, err=0.
// - start, len_words=2, bytes 13,00,00,00,93,08,10,00 back-to-back -> writes (addr 0x0, din 0x00000013)
//   and (addr 0x4, din 0x00100893), mem_we=4'hF; then done=1, core_rst=0, words_written=2.
// - start, len_words=0 -> no mem_en; done=1 the next cycle. start, len_words=CAP+1 -> err=1, no writes.
// - len_words=3, abort after 6 bytes -> exactly one write (addr 0); IDLE; core_rst=1; 7th byte not accepted.
// - s_valid toggled randomly, len_words=CAP -> CAP writes, last at addr (CAP-1)<<2, no address wrap.
// - [LOADER_CHECKSUM_EN] words 0x00000013, 0x00100893:
//   checksum 0x001008A6 -> done=1; checksum 0x001008A7 -> err=1, core_rst=1.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time sequencer for instruction-memory port B.
// Packs a little-endian byte stream into 32-bit words and writes them at
// consecutive word addresses starting at 0. The core is held in reset until
// the load completes.
// Optional feature macro: LOADER_CHECKSUM_EN. When it is defined, a trailing
// 32-bit checksum must follow the data. The checksum is the sum of all written
// words mod 2^32, and it must match before done is raised.
module instr_mem_loader #(
  parameter int INSTR_MEM_LEN = 15,
  parameter int INSTR_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              len_words,
  input  logic                     abort,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic                     mem_en,
  output logic [3:0]               mem_we,
  output logic [INSTR_MEM_LEN-1:0] mem_addr,
  output logic [INSTR_WIDTH-1:0]   mem_din,
  output logic                     core_rst,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [INSTR_MEM_LEN-2:0] words_written
);

  localparam logic [31:0]              CAP    = 32'd1 << (INSTR_MEM_LEN - 2);
  localparam logic [INSTR_MEM_LEN-2:0] WW_ONE = {{(INSTR_MEM_LEN-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [1:0]                 r_byteCnt;
  logic [23:0]                r_word;
  logic [31:0]                r_lenWords;
  logic [INSTR_MEM_LEN-2:0]   r_wordsWritten;
  logic                       r_sReady;
  logic                       r_memEn;
  logic [3:0]                 r_memWe;
  logic [INSTR_MEM_LEN-1:0]   r_memAddr;
  logic [INSTR_WIDTH-1:0]     r_memDin;
  logic                       r_coreRst;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_WIDTH-1:0]     r_sum;
`endif

  logic                       w_accept;
  logic                       w_lastByte;
  logic                       w_lastWord;
  logic [INSTR_WIDTH-1:0]     w_fullWord;

  // Bytes arrive low byte first, so the newest byte forms the top of the word.
  assign w_accept   = s_valid & r_sReady;
  assign w_lastByte = w_accept & (r_byteCnt == 2'd3);
  assign w_fullWord = {s_data, r_word};
  assign w_lastWord = ((32'(r_wordsWritten) + 32'd1) == r_lenWords);

  // The status flags are a pure function of the state being entered.
  // Order of the returned bits: {s_ready, busy, core_rst, done, err}.
  function automatic logic [4:0] stateFlags(input state_t s);
    case (s)
      S_RECV:  stateFlags = 5'b11100;
      S_WRITE: stateFlags = 5'b01100;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:  stateFlags = 5'b11100;
`endif
      S_DONE:  stateFlags = 5'b00010;
      S_ERR:   stateFlags = 5'b00101;
      default: stateFlags = 5'b00100;
    endcase
  endfunction

  // Next-state selection: abort wins over everything; start only from rest states.
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            if (len_words == 32'd0)    w_next = S_DONE;
            else if (len_words > CAP)  w_next = S_ERR;
            else                       w_next = S_RECV;
          end
        end
        S_RECV: begin
          if (w_lastByte) w_next = S_WRITE;
        end
        S_WRITE: begin
          if (w_lastWord) begin
`ifdef LOADER_CHECKSUM_EN
            w_next = S_CSUM;
`else
            w_next = S_DONE;
`endif
          end else begin
            w_next = S_RECV;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_lastByte) w_next = (w_fullWord == r_sum) ? S_DONE : S_ERR;
        end
`endif
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State register, registered outputs and the byte-packing datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_byteCnt      <= 2'd0;
      r_word         <= 24'd0;
      r_lenWords     <= 32'd0;
      r_wordsWritten <= '0;
      r_sReady       <= 1'b0;
      r_memEn        <= 1'b0;
      r_memWe        <= 4'h0;
      r_memAddr      <= '0;
      r_memDin       <= '0;
      r_coreRst      <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum          <= '0;
`endif
    end else begin
      r_state <= w_next;
      {r_sReady, r_busy, r_coreRst, r_done, r_err} <= stateFlags(w_next);
      r_memEn <= 1'b0;
      r_memWe <= 4'h0;
      if (abort) begin
        r_byteCnt <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
              r_lenWords     <= len_words;
              r_wordsWritten <= '0;
              r_byteCnt      <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
              r_sum          <= '0;
`endif
            end
          end
          S_RECV: begin
            if (w_accept) begin
              r_word    <= {s_data, r_word[23:8]};
              r_byteCnt <= r_byteCnt + 2'd1;
              if (r_byteCnt == 2'd3) begin
                r_memEn   <= 1'b1;
                r_memWe   <= 4'hF;
                r_memAddr <= {r_wordsWritten[INSTR_MEM_LEN-3:0], 2'b00};
                r_memDin  <= w_fullWord;
              end
            end
          end
          S_WRITE: begin
            r_wordsWritten <= r_wordsWritten + WW_ONE;
`ifdef LOADER_CHECKSUM_EN
            r_sum          <= r_sum + r_memDin;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (w_accept) begin
              r_word    <= {s_data, r_word[23:8]};
              r_byteCnt <= r_byteCnt + 2'd1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign s_ready       = r_sReady;
  assign mem_en        = r_memEn;
  assign mem_we        = r_memWe;
  assign mem_addr      = r_memAddr;
  assign mem_din       = r_memDin;
  assign core_rst      = r_coreRst;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign words_written = r_wordsWritten;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized self-checking bench for instr_mem_loader.
// A behavioural model tracks the loader in terms of bytes, words and
// outcomes. A compare process checks every DUT output against the model on
// every falling edge. Literal expectations from the worked examples pin the
// model. Define LOADER_CHECKSUM_EN to exercise the checksum variant.
`timescale 1ns/1ps
module tb_instr_mem_loader;

  localparam int MEM_LEN = 10;
  localparam int CAP     = 1 << (MEM_LEN - 2);

  logic                clk;
  logic                rst;
  logic                start;
  logic [31:0]         len_words;
  logic                abort;
  logic                s_valid;
  logic [7:0]          s_data;
  logic                s_ready;
  logic                mem_en;
  logic [3:0]          mem_we;
  logic [MEM_LEN-1:0]  mem_addr;
  logic [31:0]         mem_din;
  logic                core_rst;
  logic                busy;
  logic                done;
  logic                err;
  logic [MEM_LEN-2:0]  words_written;

  instr_mem_loader #(.INSTR_MEM_LEN(MEM_LEN), .INSTR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err),
    .words_written(words_written)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checksTotal  = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  // Model state: load progress expressed as byte/word counts and outcome flags.
  bit          mLoading, mWritePending, mCsum, mDone, mErr, mWwKnown;
  int          mLen, mWords, mBytes, mCsumBytes;
  logic [31:0] mWord, mSum, mCsumWord;

  // Log of writes seen on port B, used by the literal checks.
  logic [31:0] logAddr[$];
  logic [31:0] logDin[$];
  logic [31:0] logWe[$];
  logic [7:0]  txBytes[$];

  task automatic modelReset();
    mLoading = 0; mWritePending = 0; mCsum = 0; mDone = 0; mErr = 0;
    mWwKnown = 1; mLen = 0; mWords = 0; mBytes = 0; mCsumBytes = 0;
    mWord = 0; mSum = 0; mCsumWord = 0;
  endtask

  // Compare every output against the model, then advance the model by one edge.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst.s_ready", 32'(s_ready), 0);
      checkOutput("rst.mem_en", 32'(mem_en), 0);
      checkOutput("rst.mem_we", 32'(mem_we), 0);
      checkOutput("rst.mem_addr", 32'(mem_addr), 0);
      checkOutput("rst.mem_din", mem_din, 0);
      checkOutput("rst.core_rst", 32'(core_rst), 1);
      checkOutput("rst.busy", 32'(busy), 0);
      checkOutput("rst.done", 32'(done), 0);
      checkOutput("rst.err", 32'(err), 0);
      checkOutput("rst.words_written", 32'(words_written), 0);
      modelReset();
    end else begin
      checkOutput("s_ready", 32'(s_ready), 32'((mLoading || mCsum) && !mWritePending));
      checkOutput("busy", 32'(busy), 32'(mLoading || mCsum));
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("err", 32'(err), 32'(mErr));
      checkOutput("core_rst", 32'(core_rst), 32'(!mDone));
      checkOutput("mem_en", 32'(mem_en), 32'(mWritePending));
      checkOutput("mem_we", 32'(mem_we), mWritePending ? 32'hF : 32'h0);
      if (mWritePending) begin
        checkOutput("mem_addr", 32'(mem_addr), 32'((mWords * 4) % (1 << MEM_LEN)));
        checkOutput("mem_din", mem_din, mWord);
      end
      if (mWwKnown) checkOutput("words_written", 32'(words_written), 32'(mWords));
      if (mem_en) begin
        logAddr.push_back(32'(mem_addr));
        logDin.push_back(mem_din);
        logWe.push_back(32'(mem_we));
      end

      if (abort) begin
        mLoading = 0; mWritePending = 0; mCsum = 0; mDone = 0; mErr = 0; mWwKnown = 0;
      end else if (!mLoading && !mCsum) begin
        if (start) begin
          mDone = 0; mErr = 0;
          if (len_words == 0) begin
            mDone = 1; mWwKnown = 0;
          end else if (len_words > CAP) begin
            mErr = 1; mWwKnown = 0;
          end else begin
            mLoading = 1; mLen = int'(len_words); mWords = 0; mBytes = 0;
            mWord = 0; mSum = 0; mWwKnown = 1;
          end
        end
      end else if (mWritePending) begin
        mWritePending = 0;
        mSum = mSum + mWord;
        mWords++;
        if (mWords == mLen) begin
          mLoading = 0;
`ifdef LOADER_CHECKSUM_EN
          mCsum = 1; mCsumBytes = 0; mCsumWord = 0;
`else
          mDone = 1;
`endif
        end
      end else if (s_valid) begin
        if (mLoading) begin
          if (mBytes % 4 == 0) mWord = 0;
          mWord = mWord | (32'(s_data) << (8 * (mBytes % 4)));
          mBytes++;
          if (mBytes % 4 == 0) mWritePending = 1;
        end else begin
          mCsumWord = mCsumWord | (32'(s_data) << (8 * mCsumBytes));
          mCsumBytes++;
          if (mCsumBytes == 4) begin
            mCsum = 0;
            if (mCsumWord == mSum) mDone = 1;
            else mErr = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] len);
    start = 1'b1;
    len_words = len;
    tick();
    start = 1'b0;
  endtask

  task automatic pulseAbort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) txBytes.push_back(w[8*i +: 8]);
  endtask

  task automatic clearLog();
    logAddr.delete();
    logDin.delete();
    logWe.delete();
  endtask

  // Feed txBytes with random valid gaps; optional stray start pulses while loading.
  task automatic sendStream(input int pct, input bit noise);
    int budget = 20000;
    bit acc;
    while (txBytes.size() > 0 && budget > 0) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = s_valid ? txBytes[0] : 8'($urandom);
      if (noise && $urandom_range(49) == 0) begin
        start = 1'b1;
        len_words = $urandom_range(5);
      end
      acc = s_valid && s_ready;
      tick();
      start = 1'b0;
      if (acc) void'(txBytes.pop_front());
      budget--;
    end
    s_valid = 1'b0;
    if (budget == 0) checkOutput("streamTimeout", 32'(txBytes.size()), 0);
  endtask

  task automatic waitDone(input int budget);
    while (!(done || err) && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("doneOrErrReached", 32'(done || err), 1);
  endtask

  task automatic randomLoad(input int len, input int pct, input bit allowBadSum);
    logic [31:0] w;
    logic [31:0] sum = 0;
    applyStimulus(32'(len));
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      sum = sum + w;
      pushWord(w);
    end
`ifdef LOADER_CHECKSUM_EN
    if (allowBadSum && $urandom_range(1) == 1) sum = sum ^ (32'd1 << $urandom_range(31));
    pushWord(sum);
`else
    if (allowBadSum) sum = 0;
`endif
    sendStream(pct, 1'b1);
    waitDone(100);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len_words = 32'd0; abort = 1'b0;
    s_valid = 1'b0; s_data = 8'd0;
    repeat (3) tick();
    checkOutput("reset.core_rst", 32'(core_rst), 1);
    checkOutput("reset.s_ready", 32'(s_ready), 0);
    checkOutput("reset.mem_en", 32'(mem_en), 0);
    checkOutput("reset.done", 32'(done), 0);
    checkOutput("reset.err", 32'(err), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Two-word example load, back-to-back bytes.
    clearLog();
    applyStimulus(2);
    pushWord(32'h0000_0013);
    pushWord(32'h0010_0893);
`ifdef LOADER_CHECKSUM_EN
    pushWord(32'h0010_08A6);
`endif
    sendStream(100, 1'b0);
    waitDone(50);
    checkOutput("two.writes", 32'(logAddr.size()), 2);
    if (logAddr.size() >= 2) begin
      checkOutput("two.addr0", logAddr[0], 32'h0);
      checkOutput("two.din0", logDin[0], 32'h0000_0013);
      checkOutput("two.we0", logWe[0], 32'hF);
      checkOutput("two.addr1", logAddr[1], 32'h4);
      checkOutput("two.din1", logDin[1], 32'h0010_0893);
    end
    checkOutput("two.done", 32'(done), 1);
    checkOutput("two.core_rst", 32'(core_rst), 0);
    checkOutput("two.words_written", 32'(words_written), 2);

`ifdef LOADER_CHECKSUM_EN
    // Same words with a wrong checksum.
    pulseAbort();
    applyStimulus(2);
    pushWord(32'h0000_0013);
    pushWord(32'h0010_0893);
    pushWord(32'h0010_08A7);
    sendStream(100, 1'b0);
    waitDone(50);
    checkOutput("badsum.err", 32'(err), 1);
    checkOutput("badsum.done", 32'(done), 0);
    checkOutput("badsum.core_rst", 32'(core_rst), 1);
`endif

    // Zero-length load completes immediately.
    pulseAbort();
    checkOutput("abort.done", 32'(done), 0);
    clearLog();
    applyStimulus(0);
    checkOutput("zero.done", 32'(done), 1);
    repeat (2) tick();
    checkOutput("zero.writes", 32'(logAddr.size()), 0);

    // Over-capacity request errors without writing.
    clearLog();
    applyStimulus(32'(CAP + 1));
    checkOutput("over.err", 32'(err), 1);
    checkOutput("over.core_rst", 32'(core_rst), 1);
    repeat (3) tick();
    checkOutput("over.writes", 32'(logAddr.size()), 0);

    // Abort after six bytes of a three-word load.
    clearLog();
    applyStimulus(3);
    for (int i = 0; i < 6; i++) txBytes.push_back(8'(8'hA0 + i));
    sendStream(100, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hA6;
    abort   = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("abort.s_ready", 32'(s_ready), 0);
      tick();
    end
    s_valid = 1'b0;
    checkOutput("abort.writes", 32'(logAddr.size()), 1);
    if (logAddr.size() >= 1) begin
      checkOutput("abort.addr0", logAddr[0], 32'h0);
      checkOutput("abort.din0", logDin[0], 32'hA3A2_A1A0);
    end
    checkOutput("abort.core_rst", 32'(core_rst), 1);
    checkOutput("abort.busy", 32'(busy), 0);

    // Asynchronous reset in the middle of a load.
    clearLog();
    applyStimulus(3);
    for (int i = 0; i < 5; i++) txBytes.push_back(8'($urandom));
    sendStream(100, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rstMid.core_rst", 32'(core_rst), 1);
    checkOutput("rstMid.s_ready", 32'(s_ready), 0);
    checkOutput("rstMid.busy", 32'(busy), 0);
    checkOutput("rstMid.mem_en", 32'(mem_en), 0);
    checkOutput("rstMid.writes", 32'(logAddr.size()), 1);
    tick();
    rst = 1'b0;
    tick();

    // Randomized short loads with random gaps, stray starts and occasional aborts.
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(3) == 0) pulseAbort();
      randomLoad($urandom_range(1, 8), $urandom_range(30, 100), 1'b1);
      repeat ($urandom_range(0, 4)) tick();
    end

    // Full-capacity load with a toggling valid.
    clearLog();
    randomLoad(CAP, 60, 1'b0);
    checkOutput("cap.writes", 32'(logAddr.size()), 32'(CAP));
    if (logAddr.size() == CAP) checkOutput("cap.lastAddr", logAddr[CAP-1], 32'((CAP - 1) << 2));
    checkOutput("cap.done", 32'(done), 1);
    checkOutput("cap.words_written", 32'(words_written), 32'(CAP));
    repeat (3) tick();

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
